// File: rtl/hlsm_sched_param.sv
// hlsm_sched_param: parametrised multi-cycle scheduled datapath.
// Computes d=a+b, e=a+c, f=a-b, eq=(d==e), lt=(d<e),
// g=lt?d:e, h=eq?g:f, x=g<<lt, z=h>>eq (arithmetic if ARITH_SHR).
// Schedule: IDLE -> CALC -> CMP -> WAIT(xWAIT_CYCLES) -> SEL -> OUT -> IDLE.
// Ports:
//   Clk      rising-edge clock
//   Rst      asynchronous reset, active-high
//   Start    job request, sampled only in IDLE
//   a,b,c    signed operands, latched with an accepted Start
//   Busy     high while not IDLE (decoded from state)
//   Done     one-cycle pulse when x,z carry a new result
//   x,z      registered signed results
module hlsm_sched_param #(
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned ARITH_SHR   = 1
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    output logic                        Busy,
    output logic                        Done,
    output logic signed [DATAWIDTH-1:0] x,
    output logic signed [DATAWIDTH-1:0] z
);

    localparam int unsigned CW        = 8;
    localparam int unsigned WAIT_INIT = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_CMP  = 3'd2,
        S_WAIT = 3'd3,
        S_SEL  = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t state, state_n;

    logic signed [DATAWIDTH-1:0] ra, rb, rc;
    logic signed [DATAWIDTH-1:0] d, e, f, g;
    logic                        eq, lt;
    logic [CW-1:0]               cnt;

    logic signed [DATAWIDTH-1:0] h_c;
    logic signed [DATAWIDTH-1:0] x_n;
    logic signed [DATAWIDTH-1:0] z_n;

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (Start) state_n = S_CALC;
            S_CALC: state_n = S_CMP;
            S_CMP:  state_n = (WAIT_CYCLES == 0) ? S_SEL : S_WAIT;
            S_WAIT: if (cnt == '0) state_n = S_SEL;
            S_SEL:  state_n = S_OUT;
            S_OUT:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign Busy = (state != S_IDLE);

    // Result-stage combinational terms
    always_comb begin
        h_c = eq ? g : f;
        x_n = g << lt;
        z_n = (ARITH_SHR != 0) ? (h_c >>> eq) : (h_c >> eq);
    end

    // Datapath registers, each updated only in its scheduled state
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ra   <= '0;
            rb   <= '0;
            rc   <= '0;
            d    <= '0;
            e    <= '0;
            f    <= '0;
            g    <= '0;
            eq   <= 1'b0;
            lt   <= 1'b0;
            cnt  <= '0;
            x    <= '0;
            z    <= '0;
            Done <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        ra <= a;
                        rb <= b;
                        rc <= c;
                    end
                end
                S_CALC: begin
                    d <= ra + rb;
                    e <= ra + rc;
                    f <= ra - rb;
                end
                S_CMP: begin
                    eq  <= (d == e);
                    lt  <= (d < e);
                    cnt <= CW'(WAIT_INIT);
                end
                S_WAIT: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                S_SEL: begin
                    g <= lt ? d : e;
                end
                S_OUT: begin
                    x    <= x_n;
                    z    <= z_n;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hlsm_sched_param.sv
// Scoreboard bench for hlsm_sched_param: dut0 uses the default parameters,
// dut1 uses WAIT_CYCLES=0 and logical right shift.
module tb_hlsm_sched_param;

    logic               Clk = 1'b0;
    logic               Rst = 1'b1;
    logic               start0 = 1'b0, start1 = 1'b0;
    logic signed [31:0] a0 = '0, b0 = '0, c0 = '0;
    logic signed [31:0] a1 = '0, b1 = '0, c1 = '0;
    logic               busy0, done0, busy1, done1;
    logic signed [31:0] x0, z0, x1, z1;

    hlsm_sched_param #(.DATAWIDTH(32), .WAIT_CYCLES(5), .ARITH_SHR(1)) dut0 (
        .Clk(Clk), .Rst(Rst), .Start(start0), .a(a0), .b(b0), .c(c0),
        .Busy(busy0), .Done(done0), .x(x0), .z(z0)
    );

    hlsm_sched_param #(.DATAWIDTH(32), .WAIT_CYCLES(0), .ARITH_SHR(0)) dut1 (
        .Clk(Clk), .Rst(Rst), .Start(start1), .a(a1), .b(b1), .c(c1),
        .Busy(busy1), .Done(done1), .x(x1), .z(z1)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        logic [31:0] x;
        logic [31:0] z;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Monitor for dut0
    always @(negedge Clk) begin : mon0
        exp_t ex;
        if (!Rst && done0 === 1'b1) begin
            if (q0.size() == 0) chk("dut0 unexpected Done", 32'(done0), 32'd0);
            else begin
                ex = q0.pop_front();
                chk("dut0 x", x0, ex.x);
                chk("dut0 z", z0, ex.z);
                chk("dut0 Done edge", 32'(cyc), 32'(ex.cyc));
            end
        end
    end

    // Monitor for dut1
    always @(negedge Clk) begin : mon1
        exp_t ex;
        if (!Rst && done1 === 1'b1) begin
            if (q1.size() == 0) chk("dut1 unexpected Done", 32'(done1), 32'd0);
            else begin
                ex = q1.pop_front();
                chk("dut1 x", x1, ex.x);
                chk("dut1 z", z1, ex.z);
                chk("dut1 Done edge", 32'(cyc), 32'(ex.cyc));
            end
        end
    end

    // Caller is at #1 after a negedge; Start is seen on the next posedge.
    task automatic job(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] xe, input logic [31:0] ze);
        if (sel == 0) begin
            a0 = a; b0 = b; c0 = c; start0 = 1'b1;
            q0.push_back('{x: xe, z: ze, cyc: cyc + 1 + 9});
        end else begin
            a1 = a; b1 = b; c1 = c; start1 = 1'b1;
            q1.push_back('{x: xe, z: ze, cyc: cyc + 1 + 4});
        end
        @(negedge Clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk); #1;
            if (sel == 0 && !busy0 && q0.size() == 0) return;
            if (sel == 1 && !busy1 && q1.size() == 0) return;
        end
        chk(sel == 0 ? "dut0 completion timeout" : "dut1 completion timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #1;
        chk("reset Busy0", 32'(busy0), 32'd0);
        chk("reset Done0", 32'(done0), 32'd0);
        chk("reset x0", x0, 32'd0);
        chk("reset z0", z0, 32'd0);
        chk("reset Busy1", 32'(busy1), 32'd0);
        repeat (2) @(negedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk); #1;

        // Basic vectors on dut0
        job(0, 32'd5, 32'd3, 32'd10, 32'd16, 32'd2);
        chk("Busy0 after accept", 32'(busy0), 32'd1);
        wait_idle(0);
        job(0, 32'd4, 32'd6, 32'd6, 32'd10, 32'd5);
        wait_idle(0);
        job(0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h0000_0000, 32'h7FFF_FFFE);
        wait_idle(0);
        job(0, -32'sd3, -32'sd2, -32'sd2, 32'hFFFF_FFFB, 32'hFFFF_FFFD);
        wait_idle(0);

        // Start pulse with different operands during WAIT is ignored
        job(0, 32'd1, 32'd2, 32'd0, 32'h0000_0001, 32'hFFFF_FFFF);
        repeat (3) @(negedge Clk);
        #1;
        chk("Busy0 in WAIT", 32'(busy0), 32'd1);
        a0 = 32'd5; b0 = 32'd3; c0 = 32'd10; start0 = 1'b1;
        @(negedge Clk); #1 start0 = 1'b0;
        wait_idle(0);

        // Back-to-back: Start during the Done cycle is accepted
        job(0, 32'd5, 32'd3, 32'd10, 32'd16, 32'd2);
        for (int i = 0; i < 20; i++) begin
            if (done0) break;
            @(negedge Clk); #1;
        end
        chk("Done0 seen for back-to-back", 32'(done0), 32'd1);
        job(0, 32'd4, 32'd6, 32'd6, 32'd10, 32'd5);
        wait_idle(0);

        // dut1: zero wait slots, logical shift
        job(1, -32'sd3, -32'sd2, -32'sd2, 32'hFFFF_FFFB, 32'h7FFF_FFFD);
        wait_idle(1);
        job(1, 32'd5, 32'd3, 32'd10, 32'd16, 32'd2);
        wait_idle(1);

        // Reset in the middle of WAIT aborts the job
        job(0, 32'd5, 32'd3, 32'd10, 32'd16, 32'd2);
        repeat (3) @(negedge Clk);
        #1 Rst = 1'b1;
        q0.delete();
        #1;
        chk("mid-job reset x0", x0, 32'd0);
        chk("mid-job reset z0", z0, 32'd0);
        chk("mid-job reset Done0", 32'(done0), 32'd0);
        chk("mid-job reset Busy0", 32'(busy0), 32'd0);
        @(negedge Clk); #1 Rst = 1'b0;
        repeat (12) @(negedge Clk);
        #1;
        job(0, 32'd4, 32'd6, 32'd6, 32'd10, 32'd5);
        wait_idle(0);

        chk("dut0 queue drained", 32'(q0.size()), 32'd0);
        chk("dut1 queue drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
